// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// requester count, FSM state encoding and the grant-to-select encoder.
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // A one-hot grant maps onto the two mux select lines; a zero grant yields 00.
  function automatic logic [1:0] onehot_to_sel(input logic [3:0] oh);
    logic [1:0] sel;
    sel[0] = oh[1] | oh[3];
    sel[1] = oh[2] | oh[3];
    return sel;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux.sv
// DATA_W-wide 4:1 data multiplexer, steered by the registered select lines.
module rr_mux4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic         sel1,
  input  logic         sel0,
  output logic [W-1:0] y
);

  always_comb begin
    case ({sel1, sel0})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter_pick.sv
// Rotating-priority picker: the first requester at or after ptr, modulo 4,
// wins the arbitration.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  // Scan from lowest to highest priority so that the last hit is the best one.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing one valid/ready channel.
// Grants are bounded bursts, and hand-over to the next owner has no bubble.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sel1,
  output logic              sel0,
  output logic [3:0]        gnt,
  output logic [3:0]        ack
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [1:0]        owner;
  logic [1:0]        pick_ptr;
  logic [1:0]        winner;
  logic              any;
  logic [3:0]        win_oh;
  logic              in_grant;
  logic              xfer;
  logic              rel;
  logic [DATA_W-1:0] mux_y;

  assign owner    = sel_q;
  assign in_grant = (state_q == ST_GRANT);

  // While granted, the picker already looks from owner+1 so a release can
  // re-arbitrate in the same edge; the old owner naturally ranks last.
  assign pick_ptr = in_grant ? owner + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  rr_mux4 #(
    .W (DATA_W)
  ) u_mux (
    .d0   (in0),
    .d1   (in1),
    .d2   (in2),
    .d3   (in3),
    .sel1 (sel_q[1]),
    .sel0 (sel_q[0]),
    .y    (mux_y)
  );

  assign win_oh    = 4'b0001 << winner;
  assign out_valid = in_grant & req[owner];
  assign out_data  = out_valid ? mux_y : '0;
  assign xfer      = out_valid & out_ready;
  assign ack       = gnt_q & {NUM_REQ{xfer}};
  assign rel       = in_grant & ((xfer & (cnt_q == LAST_BEAT)) | ~req[owner]);

  assign gnt  = gnt_q;
  assign sel1 = sel_q[1];
  assign sel0 = sel_q[0];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          sel_d   = onehot_to_sel(win_oh);
          cnt_d   = 4'd0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          ptr_d = owner + 2'd1;
          cnt_d = 4'd0;
          if (any) begin
            gnt_d = win_oh;
            sel_d = onehot_to_sel(win_oh);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed scoreboard bench for rr_mux4_arbiter: each expected beat is queued
// up front and popped by a monitor whenever the DUT acks a beat.
module tb_rr_mux4_arbiter;

  localparam int DATA_W = 8;
  localparam int MB     = 4;

  typedef struct packed {
    logic [1:0]        who;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] in0, in1, in2, in3;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              sel1, sel0;
  logic [3:0]        gnt;
  logic [3:0]        ack;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  rr_mux4_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel1      (sel1),
    .sel0      (sel0),
    .gnt       (gnt),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushBeats(input logic [1:0] who, input logic [DATA_W-1:0] data, input int n);
    beat_t b;
    b.who  = who;
    b.data = data;
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  function automatic logic [1:0] encSel(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Monitor: sample mid-cycle, the beat shown now is the one taken at the next edge.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (!out_valid) checkOutput("data_zero_idle", 32'(out_data), 32'd0);
      if (gnt != 4'b0000) checkOutput("sel_matches_gnt", 32'({sel1, sel0}), 32'(encSel(gnt)));
      if (ack != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'(ack), 32'd0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_ack", 32'(ack), 32'(4'b0001 << b.who));
          checkOutput("beat_data", 32'(out_data), 32'(b.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in0 = 8'h3C;
    in1 = 8'hA5;
    in2 = 8'h5A;
    in3 = 8'hC3;
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b0);

    // Reset holds everything cleared, even across a clock edge.
    #2;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_sel", 32'({sel1, sel0}), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    tick(1);
    checkOutput("rst_gnt_edge", 32'(gnt), 32'd0);
    #2 rst_n = 1'b1;
    tick(1);
    checkOutput("first_gnt", 32'(gnt), 32'b0001);
    checkOutput("first_sel", 32'({sel1, sel0}), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("idle_gnt", 32'(gnt), 32'd0);

    // Burst cap on a lone requester; pointer is 1 here.
    applyStimulus(4'b0001, 1'b1);
    pushBeats(2'd0, 8'h3C, MB);
    tick(1);
    checkOutput("cap_gnt", 32'(gnt), 32'b0001);
    tick(MB);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("cap_regrant", 32'(gnt), 32'b0001);
    checkOutput("cap_queue", 32'(exp_q.size()), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("cap_idle", 32'(gnt), 32'd0);

    // Round robin with all requesting, starting from pointer 1.
    applyStimulus(4'b1111, 1'b1);
    pushBeats(2'd1, 8'hA5, MB);
    pushBeats(2'd2, 8'h5A, MB);
    pushBeats(2'd3, 8'hC3, MB);
    pushBeats(2'd0, 8'h3C, MB);
    tick(1);
    checkOutput("rr_first_gnt", 32'(gnt), 32'b0010);
    tick(4 * MB);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("rr_wrap_gnt", 32'(gnt), 32'b0010);
    checkOutput("rr_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure on owner 2, then a full burst.
    applyStimulus(4'b1101, 1'b0);
    tick(1);
    checkOutput("bp_gnt", 32'(gnt), 32'b0100);
    checkOutput("bp_sel", 32'({sel1, sel0}), 32'd2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_data", 32'(out_data), 32'h5A);
      checkOutput("bp_ack", 32'(ack), 32'd0);
      tick(1);
    end
    applyStimulus(4'b1100, 1'b1);
    pushBeats(2'd2, 8'h5A, MB);
    tick(MB);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("bp_next_gnt", 32'(gnt), 32'b1000);
    checkOutput("bp_next_sel", 32'({sel1, sel0}), 32'd3);
    checkOutput("bp_queue", 32'(exp_q.size()), 32'd0);

    // Withdrawal: owner 1 leaves after one beat with ready low.
    applyStimulus(4'b0010, 1'b0);
    tick(1);
    checkOutput("wd_owner1", 32'(gnt), 32'b0010);
    applyStimulus(4'b1010, 1'b1);
    pushBeats(2'd1, 8'hA5, 1);
    tick(1);
    applyStimulus(4'b1000, 1'b0);
    tick(1);
    checkOutput("wd_gnt", 32'(gnt), 32'b1000);
    checkOutput("wd_sel", 32'({sel1, sel0}), 32'd3);
    checkOutput("wd_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges in the middle of owner 3's burst.
    applyStimulus(4'b1000, 1'b1);
    pushBeats(2'd3, 8'hC3, 2);
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_gnt", 32'(gnt), 32'd0);
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_data", 32'(out_data), 32'd0);
    checkOutput("arst_ack", 32'(ack), 32'd0);
    checkOutput("arst_sel", 32'({sel1, sel0}), 32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("arst_idle", 32'(gnt), 32'd0);
    checkOutput("arst_queue", 32'(exp_q.size()), 32'd0);

    // Pointer returned to 0 by the reset.
    applyStimulus(4'b1111, 1'b0);
    tick(1);
    checkOutput("arst_ptr_gnt", 32'(gnt), 32'b0001);

    tick(2);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
